// File: rtl/lab3_multi_timer_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
package lab3_multi_timer_pkg;

  // Per-channel register index (low two address bits)
  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_CONTROL = 2'd1,
    REG_PERIOD  = 2'd2,
    REG_SNAP    = 2'd3
  } reg_idx_e;

  // CONTROL bit positions
  localparam int unsigned CTRL_ITO          = 0;
  localparam int unsigned CTRL_CONT         = 1;
  localparam int unsigned CTRL_START        = 2;
  localparam int unsigned CTRL_STOP         = 3;
  localparam int unsigned CTRL_PRESCALE_LSB = 8;

  // STATUS bit positions
  localparam int unsigned STAT_TO  = 0;
  localparam int unsigned STAT_RUN = 1;

endpackage

// File: rtl/lab3_timer_channel.sv
// One timer channel: prescaler, down-counter, RUN/TO flags, CONTROL, PERIOD and SNAP.
module lab3_timer_channel
  import lab3_multi_timer_pkg::*;
#(
  parameter int unsigned COUNTER_W    = 32,
  parameter int unsigned PRESCALE_W   = 8,
  parameter logic [31:0] RESET_PERIOD = 32'd24999999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wr,
  input  reg_idx_e    i_reg,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq
);

  localparam logic [COUNTER_W-1:0] RST_PERIOD = RESET_PERIOD[COUNTER_W-1:0];

  logic                  r_to;
  logic                  r_run;
  logic                  r_ito;
  logic                  r_cont;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_pre;
  logic [COUNTER_W-1:0]  r_period;
  logic [COUNTER_W-1:0]  r_cnt;
  logic [COUNTER_W-1:0]  r_snap;

  logic w_wr_status;
  logic w_wr_ctrl;
  logic w_wr_period;
  logic w_wr_snap;
  logic w_start;
  logic w_stop;
  logic w_tick;
  logic w_expire;
  logic w_unused;

  assign w_wr_status = i_wr && (i_reg == REG_STATUS);
  assign w_wr_ctrl   = i_wr && (i_reg == REG_CONTROL);
  assign w_wr_period = i_wr && (i_reg == REG_PERIOD);
  assign w_wr_snap   = i_wr && (i_reg == REG_SNAP);
  assign w_start     = w_wr_ctrl && i_wdata[CTRL_START];
  assign w_stop      = w_wr_ctrl && i_wdata[CTRL_STOP];
  assign w_tick      = r_run && (r_pre == r_prescale);
  assign w_expire    = w_tick && (r_cnt == '0);
  assign w_unused    = ^i_wdata;

  // Prescaler: counts while running, wraps on match; restarts on START or PERIOD write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre <= '0;
    end else if (w_wr_period || w_start) begin
      r_pre <= '0;
    end else if (r_run) begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end
  end

  // Down-counter: PERIOD write force-reloads, otherwise decrement/reload on tick
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= RST_PERIOD;
    end else if (w_wr_period) begin
      r_cnt <= i_wdata[COUNTER_W-1:0];
    end else if (w_tick) begin
      r_cnt <= w_expire ? r_period : r_cnt - 1'b1;
    end
  end

  // RUN flag: PERIOD write stops, START beats STOP, one-shot expiry stops
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run <= 1'b0;
    end else if (w_wr_period) begin
      r_run <= 1'b0;
    end else if (w_start) begin
      r_run <= 1'b1;
    end else if (w_stop) begin
      r_run <= 1'b0;
    end else if (w_expire && !r_cont) begin
      r_run <= 1'b0;
    end
  end

  // TO flag: a timeout in the same cycle as a STATUS write is kept
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to <= 1'b0;
    end else begin
      r_to <= (r_to && !w_wr_status) || w_expire;
    end
  end

  // Software-visible configuration and snapshot registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ito      <= 1'b0;
      r_cont     <= 1'b0;
      r_prescale <= '0;
      r_period   <= RST_PERIOD;
      r_snap     <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_ito      <= i_wdata[CTRL_ITO];
        r_cont     <= i_wdata[CTRL_CONT];
        r_prescale <= i_wdata[CTRL_PRESCALE_LSB +: PRESCALE_W];
      end
      if (w_wr_period) begin
        r_period <= i_wdata[COUNTER_W-1:0];
      end
      if (w_wr_snap) begin
        r_snap <= r_cnt;
      end
    end
  end

  // Register read view for the currently addressed register index
  always_comb begin
    o_rdata = '0;
    case (i_reg)
      REG_STATUS: begin
        o_rdata[STAT_TO]  = r_to;
        o_rdata[STAT_RUN] = r_run;
      end
      REG_CONTROL: begin
        o_rdata[CTRL_ITO]                          = r_ito;
        o_rdata[CTRL_CONT]                         = r_cont;
        o_rdata[CTRL_PRESCALE_LSB +: PRESCALE_W]   = r_prescale;
      end
      REG_PERIOD: o_rdata[COUNTER_W-1:0] = r_period;
      REG_SNAP:   o_rdata[COUNTER_W-1:0] = r_snap;
      default:    o_rdata = '0;
    endcase
  end

  assign o_irq = r_to && r_ito;

endmodule

// File: rtl/lab3_multi_timer.sv
// NUM_CH-channel interval timer behind a single 32-bit Avalon-MM slave.
module lab3_multi_timer
  import lab3_multi_timer_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned COUNTER_W    = 32,
  parameter logic [31:0] RESET_PERIOD = 32'd24999999,
  parameter int unsigned PRESCALE_W   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_CH)+1:0]   address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic [NUM_CH-1:0]           irq_vec,
  output logic                        irq
);

  localparam int unsigned AW = $clog2(NUM_CH) + 2;

  // Channel index taken by shift so NUM_CH=1 (no channel bits) still decodes to 0
  logic [AW-1:0] w_ch;
  reg_idx_e      w_reg;
  logic          w_wr;
  logic [31:0]   w_rd [NUM_CH];
  logic [31:0]   w_mux;

  assign w_ch  = address >> 2;
  assign w_reg = reg_idx_e'(address[1:0]);
  assign w_wr  = chipselect && !write_n;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    lab3_timer_channel #(
      .COUNTER_W    (COUNTER_W),
      .PRESCALE_W   (PRESCALE_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .i_wr    (w_wr && (w_ch == AW'(g))),
      .i_reg   (w_reg),
      .i_wdata (writedata),
      .o_rdata (w_rd[g]),
      .o_irq   (irq_vec[g])
    );
  end

  // Read mux: out-of-range channel indices read as zero
  always_comb begin
    w_mux = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_ch == AW'(i)) begin
        w_mux = w_rd[i];
      end
    end
  end

  // Registered read data, refreshed every cycle regardless of chipselect
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else begin
      readdata <= w_mux;
    end
  end

  assign irq = |irq_vec;

endmodule

// File: tb/tb_lab3_multi_timer.sv
// Directed self-checking bench: a 4-channel and a 3-channel timer share one bus.
module tb_lab3_multi_timer;

  localparam logic [31:0] RP = 32'h017D783F;

  logic        clk;
  logic        reset;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata_a;
  logic [31:0] readdata_b;
  logic [3:0]  irq_vec_a;
  logic [2:0]  irq_vec_b;
  logic        irq_a;
  logic        irq_b;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } rd_exp_t;

  rd_exp_t sb[$];

  lab3_multi_timer #(.NUM_CH(4)) u_dut4 (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata_a),
    .irq_vec    (irq_vec_a),
    .irq        (irq_a)
  );

  lab3_multi_timer #(.NUM_CH(3)) u_dut3 (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata_b),
    .irq_vec    (irq_vec_b),
    .irq        (irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] ea, input logic [31:0] eb,
                    input string tag);
    rd_exp_t e;
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    e.tag = tag; e.exp_a = ea; e.exp_b = eb;
    sb.push_back(e);
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    e = sb.pop_front();
    check({e.tag, "/a"}, readdata_a, e.exp_a);
    check({e.tag, "/b"}, readdata_b, e.exp_b);
  endtask

  // Same expectation on both timers, except channel 3 does not exist in the 3-channel one
  task automatic rd1(input logic [3:0] a, input logic [31:0] e, input string tag);
    rd(a, e, (a[3:2] == 2'd3) ? 32'h0 : e, tag);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_irq(input string tag, input logic ea, input logic [3:0] va,
                           input logic eb, input logic [2:0] vb);
    check({tag, "/irq_a"}, 32'(irq_a), 32'(ea));
    check({tag, "/vec_a"}, 32'(irq_vec_a), 32'(va));
    check({tag, "/irq_b"}, 32'(irq_b), 32'(eb));
    check({tag, "/vec_b"}, 32'(irq_vec_b), 32'(vb));
  endtask

  initial begin
    reset      = 1'b1;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    // Reset defaults
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_a", readdata_a, 32'h0);
    check("rst_rd_b", readdata_b, 32'h0);
    check_irq("rst", 1'b0, 4'h0, 1'b0, 3'h0);
    reset = 1'b0;
    rd1(4'd0,  32'h0, "rst_st0");
    rd1(4'd1,  32'h0, "rst_ctl0");
    rd1(4'd2,  RP,    "rst_per0");
    rd1(4'd3,  32'h0, "rst_snp0");
    rd1(4'd12, 32'h0, "rst_st3");
    rd1(4'd13, 32'h0, "rst_ctl3");
    rd1(4'd14, RP,    "rst_per3");
    rd1(4'd15, 32'h0, "rst_snp3");

    // Continuous timeout on ch1: PERIOD=9, PRESCALE=1 -> 20 cycles per timeout
    wr(4'd6, 32'd9);
    wr(4'd5, 32'h0000_0107);
    idle(18);
    rd1(4'd4, 32'h2, "t2_pre19");
    rd1(4'd4, 32'h2, "t2_pre20");
    rd1(4'd4, 32'h3, "t2_to");
    check_irq("t2", 1'b1, 4'b0010, 1'b1, 3'b010);
    wr(4'd4, 32'h0);
    rd1(4'd4, 32'h2, "t2_clr");
    check_irq("t2_clr", 1'b0, 4'b0000, 1'b0, 3'b000);
    idle(16);
    rd1(4'd4, 32'h2, "t2_pre40");
    rd1(4'd4, 32'h3, "t2_to2");

    // STATUS write on the exact timeout edge keeps TO
    wr(4'd4, 32'h0);
    rd1(4'd4, 32'h2, "t5_clr");
    idle(16);
    wr(4'd4, 32'h0);
    rd1(4'd4, 32'h3, "t5_coll");

    // Clearing ITO drops irq but TO stays
    wr(4'd5, 32'h0000_0102);
    check_irq("t5_ito", 1'b0, 4'b0000, 1'b0, 3'b000);
    rd1(4'd4, 32'h3, "t5_to_kept");
    rd1(4'd5, 32'h102, "t5_ctrl");
    wr(4'd5, 32'h0000_010A);
    rd1(4'd4, 32'h1, "t5_stopped");
    wr(4'd4, 32'h0);

    // START|STOP together runs; PERIOD write while running stops and reloads
    wr(4'd5, 32'hC);
    rd1(4'd4, 32'h2, "t5_startstop");
    wr(4'd6, 32'd50);
    rd1(4'd4, 32'h0, "t5_per_stop");
    wr(4'd7, 32'h0);
    rd1(4'd7, 32'd50, "t5_per_cnt");
    rd1(4'd6, 32'd50, "t5_per_rd");

    // One-shot on ch2: PERIOD=3, PRESCALE=0 -> TO four cycles after START
    wr(4'd10, 32'd3);
    wr(4'd9, 32'h5);
    idle(2);
    rd1(4'd8, 32'h2, "t3_run3");
    rd1(4'd8, 32'h2, "t3_run4");
    rd1(4'd8, 32'h1, "t3_to");
    check_irq("t3", 1'b1, 4'b0100, 1'b1, 3'b100);
    wr(4'd11, 32'h0);
    rd1(4'd11, 32'd3, "t3_snap");
    wr(4'd8, 32'h0);
    idle(100);
    rd1(4'd8, 32'h0, "t3_quiet");
    rd1(4'd9, 32'h1, "t3_ctrl");

    // Stop / snapshot / resume on ch0
    wr(4'd2, 32'd1000);
    wr(4'd1, 32'h4);
    idle(99);
    wr(4'd1, 32'h8);
    wr(4'd3, 32'h0);
    rd1(4'd3, 32'd900, "t4_snap");
    idle(50);
    wr(4'd3, 32'h0);
    rd1(4'd3, 32'd900, "t4_hold");
    rd1(4'd0, 32'h0, "t4_stat");
    wr(4'd1, 32'h4);
    idle(9);
    wr(4'd3, 32'h0);
    rd1(4'd3, 32'd891, "t4_resume");

    // Channel 3: real on the 4-channel timer, out of range on the 3-channel one
    wr(4'd14, 32'd5);
    wr(4'd13, 32'h5);
    idle(8);
    rd(4'd12, 32'h1, 32'h0, "t6_st3");
    rd(4'd14, 32'd5, 32'h0, "t6_per3");
    check_irq("t6", 1'b1, 4'b1000, 1'b0, 3'b000);
    rd1(4'd10, 32'd3,    "t6_per2");
    rd1(4'd6,  32'd50,   "t6_per1");
    rd1(4'd2,  32'd1000, "t6_per0");
    rd1(4'd9,  32'h1,    "t6_ctrl2");

    // Reset while ch0 is counting
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_rd_a", readdata_a, 32'h0);
    check("t6_rst_rd_b", readdata_b, 32'h0);
    check_irq("t6_rst", 1'b0, 4'h0, 1'b0, 3'h0);
    reset = 1'b0;
    rd1(4'd0,  32'h0, "t6_rst_st0");
    rd1(4'd1,  32'h0, "t6_rst_ctl0");
    rd1(4'd2,  RP,    "t6_rst_per0");
    rd1(4'd3,  32'h0, "t6_rst_snp0");
    idle(5);
    wr(4'd3, 32'h0);
    rd1(4'd3,  RP,    "t6_rst_frozen");
    rd1(4'd12, 32'h0, "t6_rst_st3");
    rd1(4'd14, RP,    "t6_rst_per3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lab3_multi_timer.md
Name: lab3_multi_timer

Overview:
- Parametrised successor to the single interval timer: NUM_CH independent down-counters of COUNTER_W bits behind one 32-bit Avalon-MM slave.
- Each channel has a programmable clock prescaler, one-shot/continuous mode, start/stop control, snapshot capture and a maskable timeout interrupt.
- Per-channel interrupts are exported as a vector and as one OR'd line for the Nios II IRQ input.
- Sits in the lab3 Qsys system beside the existing peripherals.

Parameters:
- NUM_CH, 4: number of timer channels, 1..8.
- COUNTER_W, 32: counter/period width, 8..32.
- RESET_PERIOD, 24999999: period and counter value after reset; truncated to COUNTER_W.
- PRESCALE_W, 8: prescaler field width; tick every (prescale+1) clk cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  $clog2(NUM_CH)+2  {channel, reg[1:0]}.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq_vec  out  NUM_CH  per-channel interrupt, computed as TO & ITO.
- irq  out  1  OR of irq_vec.

Behaviour:
- Register map per channel (reg index):
  - 0 STATUS: bit0 TO, bit1 RUN (read-only). Any write clears TO.
  - 1 CONTROL: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP, bits[8+PRESCALE_W-1:8] PRESCALE. START and STOP are strobes and always read as 0.
  - 2 PERIOD: bits[COUNTER_W-1:0], read/write.
  - 3 SNAP: any write copies the live counter into SNAP; reads return SNAP.
- Address decode: channel indices >= NUM_CH read 0 and ignore writes. Unused upper bits read 0.
- Read latency: exactly 1 cycle. readdata is updated every cycle from the mux, independent of chipselect, as in the existing timer.
- Reset (synchronous, active-high): readdata=0, irq=0, irq_vec=0, TO=0, RUN=0, CONTROL=0, SNAP=0, prescaler=0, PERIOD=counter=RESET_PERIOD.
- Prescaler:
  - Counts up only while RUN=1; when it equals PRESCALE it wraps to 0 and asserts tick for one cycle.
  - PRESCALE=0 gives a tick every cycle.
  - The prescaler is cleared on START and on a PERIOD write.
- Counter, on a tick while RUN=1:
  - If counter != 0: decrement by 1.
  - If counter == 0: reload PERIOD, set TO, and clear RUN if CONT=0.
  - Timeout interval is therefore (PERIOD+1)*(PRESCALE+1) clk cycles.
- PERIOD write: on the next cycle the counter loads the new PERIOD and RUN clears (force reload). Software must START again.
- START: RUN=1 the cycle after the write. START and STOP in the same write: START wins.
- STOP: RUN=0 the cycle after the write; the counter holds its value. A later START resumes from the held value.
- Simultaneous STATUS write and timeout event on the same channel: TO=1 (the event is not lost).
- irq_vec and irq are combinational from registered TO/ITO, so they assert the cycle after TO sets.
- Clearing ITO drops irq without clearing TO.
- Reset asserted mid-count: all state returns to reset values on that edge. The counter does not run until START.

Decomposition:
- Package lab3_multi_timer_pkg holds:
  - register index constants REG_STATUS=0, REG_CONTROL=1, REG_PERIOD=2, REG_SNAP=3;
  - CONTROL bit positions (ITO, CONT, START, STOP, PRESCALE_LSB=8);
  - STATUS bit positions (TO, RUN).
- Sub-module lab3_timer_channel holds one channel's prescaler, counter, RUN, TO, CONTROL, PERIOD and SNAP. It is instantiated NUM_CH times via generate.
- The top level owns address decode, the read mux, the readdata register and the irq reduction.

Test Plan:
1. Reset defaults: assert reset 2 cycles, read every register of ch0 and ch3 -> STATUS=0, CONTROL=0, PERIOD=24999999 (0x017D783F), SNAP=0; irq=0.
2. Continuous timeout: ch1 PERIOD=9, CONTROL=0x0000_0107 (ITO, CONT, START, PRESCALE=1) -> TO rises every 20 clk; irq_vec=4'b0010 and irq=1; write STATUS -> TO=0, next timeout sets it again 20 cycles after the previous one.
3. One-shot: ch2 PERIOD=3, CONTROL=0x5 (ITO, START, PRESCALE=0) -> TO=1 after 4 clk, RUN=0, counter reads 3 via SNAP write/read; no further timeouts over 100 cycles.
4. Stop/snap/resume: ch0 PERIOD=1000, START, STOP after 100 cycles -> SNAP shows the frozen value ~900, stable over 50 cycles; START -> counting resumes from that value.
5. Collisions: STATUS write on the exact timeout cycle -> TO stays 1; CONTROL=0xC (START|STOP) -> RUN=1; PERIOD write while running -> RUN=0 and counter=new PERIOD next cycle.
6. Out-of-range and reset mid-count (NUM_CH=3): write/read address {ch=3,*} -> reads 0, no channel is affected; assert reset during counting -> all state at reset values, irq=0.
